// File: rtl/spi_master_shifter.sv
// SPI mode-0 master byte shifter: streams bytes MSB first on mosi and captures
// miso into rx_dat, keeping ssn low across back-to-back bytes of one frame.
module spi_master_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_dat,
    input  logic       tx_last,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    output logic       busy,
    output logic       sck,
    output logic       ssn,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [6:0] rx_sr_q, rx_sr_d;
    logic       last_q, last_d;
    logic       sck_q, sck_d;
    logic       ssn_q, ssn_d;
    logic       mosi_q, mosi_d;
    logic [7:0] rx_dat_q, rx_dat_d;
    logic       rx_vld_q, rx_vld_d;

    logic tick;
    logic accept;

    assign tx_rdy = (state_q == IDLE) || (state_q == WAIT);
    assign busy   = (state_q != IDLE);
    assign tick   = (div_q == DIV_LAST);
    assign accept = tx_vld && tx_rdy;

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        tx_sr_d  = tx_sr_q;
        rx_sr_d  = rx_sr_q;
        last_d   = last_q;
        sck_d    = sck_q;
        ssn_d    = ssn_q;
        mosi_d   = mosi_q;
        rx_dat_d = rx_dat_q;
        rx_vld_d = 1'b0;

        case (state_q)
            IDLE, WAIT: begin
                if (accept) begin
                    tx_sr_d = tx_dat;
                    last_d  = tx_last;
                    mosi_d  = tx_dat[7];
                    ssn_d   = 1'b0;
                    bit_d   = 3'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sck_q) begin
                        // Falling edge: capture miso, then either present the next bit or close the byte.
                        sck_d   = 1'b0;
                        rx_sr_d = {rx_sr_q[5:0], miso};
                        if (bit_q == 3'd7) begin
                            rx_dat_d = {rx_sr_q, miso};
                            rx_vld_d = 1'b1;
                            bit_d    = 3'd0;
                            state_d  = last_q ? HOLD : WAIT;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            tx_sr_d = tx_sr_q << 1;
                            mosi_d  = tx_sr_q[6];
                        end
                    end else begin
                        sck_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    ssn_d   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Divider restarts on every state change and is parked while waiting for data.
        if ((state_d != state_q) || tick || (state_q == IDLE) || (state_q == WAIT)) begin
            div_d = 8'd0;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= 8'd0;
            bit_q    <= 3'd0;
            tx_sr_q  <= 8'd0;
            rx_sr_q  <= 7'd0;
            last_q   <= 1'b0;
            sck_q    <= 1'b0;
            ssn_q    <= 1'b1;
            mosi_q   <= 1'b0;
            rx_dat_q <= 8'd0;
            rx_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_sr_q  <= tx_sr_d;
            rx_sr_q  <= rx_sr_d;
            last_q   <= last_d;
            sck_q    <= sck_d;
            ssn_q    <= ssn_d;
            mosi_q   <= mosi_d;
            rx_dat_q <= rx_dat_d;
            rx_vld_q <= rx_vld_d;
        end
    end

    assign sck    = sck_q;
    assign ssn    = ssn_q;
    assign mosi   = mosi_q;
    assign rx_dat = rx_dat_q;
    assign rx_vld = rx_vld_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed bench for spi_master_shifter (CLK_DIV=2) with an rx-byte scoreboard.
module tb_spi_master_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_dat;
    logic       tx_last;
    logic       tx_vld;
    logic       tx_rdy;
    logic [7:0] rx_dat;
    logic       rx_vld;
    logic       busy;
    logic       sck;
    logic       ssn;
    logic       mosi;
    logic       miso;

    int mode = 0; // 0: loopback, 1: miso tied 1, 2: miso tied 0

    assign miso = (mode == 0) ? mosi : (mode == 1);

    spi_master_shifter #(.CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .tx_dat(tx_dat), .tx_last(tx_last), .tx_vld(tx_vld),
        .tx_rdy(tx_rdy), .rx_dat(rx_dat), .rx_vld(rx_vld), .busy(busy),
        .sck(sck), .ssn(ssn), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] q[$];
    int acc_cyc, acc_count = 0;
    int rx_cyc, rx_count = 0;
    int rises = 0, first_rise_cyc = 0;
    int ssn_fall_cyc = 0, ssn_rise_cyc = 0, ssn_rises = 0;
    int rdy_rise_cyc = 0, wait_cycles = 0, viol = 0;
    logic [7:0] mosi_cap = 8'h00;
    logic sck_prev = 1'b0, ssn_prev = 1'b1, rdy_prev = 1'b1, first_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_vld && tx_rdy) begin
                acc_cyc = cyc;
                acc_count++;
                q.push_back((mode == 0) ? tx_dat : (mode == 1) ? 8'hFF : 8'h00);
            end
            if (rx_vld) begin
                rx_cyc = cyc;
                rx_count++;
                if (q.size() == 0) chk("rx_unexpected", 1, 0);
                else chk("rx_dat", rx_dat, q.pop_front());
            end
            if (sck && !sck_prev) begin
                rises++;
                mosi_cap = {mosi_cap[6:0], mosi};
                if (first_pend) begin
                    first_rise_cyc = cyc;
                    first_pend = 1'b0;
                end
            end
            if (!ssn && ssn_prev) begin
                ssn_fall_cyc = cyc;
                first_pend = 1'b1;
            end
            if (ssn && !ssn_prev) begin
                ssn_rise_cyc = cyc;
                ssn_rises++;
            end
            if (tx_rdy && !rdy_prev) rdy_rise_cyc = cyc;
            if (tx_rdy && busy) wait_cycles++;
            if (ssn && sck) viol++;
        end
        sck_prev = sck;
        ssn_prev = ssn;
        rdy_prev = tx_rdy;
    end

    task automatic send(input logic [7:0] d, input logic l, input logic keep);
        int n;
        logic hs;
        n = 0;
        hs = 1'b0;
        tx_dat = d;
        tx_last = l;
        tx_vld = 1'b1;
        do begin
            @(negedge clk);
            hs = tx_rdy;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 2000);
        if (!hs) chk("accept_timeout", 0, 1);
        if (!keep) tx_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 2000);
        chk("idle_timeout", busy, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int r0, rx0, sr0, bad_cnt;
        rst = 1'b1;
        tx_vld = 1'b0;
        tx_dat = 8'h00;
        tx_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sck", sck, 0);
        chk("rst_ssn", ssn, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_rx_vld", rx_vld, 0);
        chk("rst_rx_dat", rx_dat, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_tx_rdy", tx_rdy, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single byte timing, loopback
        r0 = rises;
        send(8'hA5, 1'b1, 1'b0);
        wait_idle();
        chk("a5_ssn_fall", 32'(ssn_fall_cyc - acc_cyc), 1);
        chk("a5_first_rise", 32'(first_rise_cyc - acc_cyc), 3);
        chk("a5_rx_vld_cyc", 32'(rx_cyc - acc_cyc), 33);
        chk("a5_ssn_rise", 32'(ssn_rise_cyc - acc_cyc), 35);
        chk("a5_tx_rdy_rise", 32'(rdy_rise_cyc - acc_cyc), 37);
        chk("a5_rises", 32'(rises - r0), 8);
        chk("a5_rx_dat_held", rx_dat, 8'hA5);

        // Burst of five bytes with tx_vld held
        r0 = rises;
        rx0 = rx_count;
        sr0 = ssn_rises;
        wait_cycles = 0;
        for (int i = 0; i < 5; i++) send(8'hAA + 8'(i), (i == 4), (i < 4));
        wait_idle();
        chk("burst_rises", 32'(rises - r0), 40);
        chk("burst_rx_count", 32'(rx_count - rx0), 5);
        chk("burst_ssn_rises", 32'(ssn_rises - sr0), 1);
        chk("burst_wait_cycles", 32'(wait_cycles), 4);

        // miso tied high / low
        mode = 1;
        send(8'h80, 1'b1, 1'b0);
        wait_idle();
        chk("tied1_mosi_bits", mosi_cap, 8'h80);
        chk("tied1_rx_dat", rx_dat, 8'hFF);
        mode = 2;
        send(8'h80, 1'b1, 1'b0);
        wait_idle();
        chk("tied0_rx_dat", rx_dat, 8'h00);
        mode = 0;

        // Stall in WAIT for 50 cycles
        send(8'h11, 1'b0, 1'b0);
        begin
            int n;
            n = 0;
            while (!(tx_rdy && busy) && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("wait_reached", tx_rdy && busy, 1);
        end
        bad_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(ssn == 1'b0 && sck == 1'b0 && tx_rdy == 1'b1)) bad_cnt++;
            @(posedge clk);
            #1;
        end
        chk("stall_hold", 32'(bad_cnt), 0);
        send(8'h22, 1'b1, 1'b0);
        wait_idle();
        chk("stall_rx_dat", rx_dat, 8'h22);

        // New data offered during SHIFT must not be taken
        rx0 = acc_count;
        send(8'hC3, 1'b1, 1'b1);
        tx_dat = 8'h3C;
        tx_last = 1'b0;
        bad_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_rdy) bad_cnt++;
            @(posedge clk);
            #1;
        end
        tx_vld = 1'b0;
        wait_idle();
        chk("shift_tx_rdy_low", 32'(bad_cnt), 0);
        chk("shift_no_accept", 32'(acc_count - rx0), 1);
        chk("shift_mosi_bits", mosi_cap, 8'hC3);

        // Reset mid-frame after the third sck rise
        r0 = rises;
        send(8'h77, 1'b1, 1'b0);
        begin
            int n;
            n = 0;
            while (rises < r0 + 3 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("third_rise_reached", 32'(rises - r0), 3);
        end
        rx0 = rx_count;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("abort_ssn", ssn, 1);
        chk("abort_sck", sck, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rx_vld", rx_vld, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_rx", 32'(rx_count - rx0), 0);
        send(8'h5A, 1'b1, 1'b0);
        wait_idle();
        chk("post_rst_rx_dat", rx_dat, 8'h5A);
        chk("post_rst_latency", 32'(rx_cyc - acc_cyc), 33);

        chk("scoreboard_empty", 32'(q.size()), 0);
        chk("sck_while_ssn_high", 32'(viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
